// File: rtl/snn_config_loader.sv
// Byte-serial, checksummed configuration writer for the three-neuron layer.
// Commits weights and neuron parameters atomically and gates the layer enable.
module snn_config_loader #(
    parameter logic [31:0] DEFAULT_PARAMS  = 32'h7F010200,
    parameter logic [71:0] DEFAULT_WEIGHTS = 72'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cfg_start,
    input  logic [7:0]  data_in,
    input  logic        data_valid,
    output logic        data_ready,
    input  logic        enable_in,
    output logic        enable_out,
    output logic [71:0] input_weights,
    output logic [31:0] neuron_params,
    output logic        cfg_busy,
    output logic        cfg_done,
    output logic        cfg_error
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        CHECK = 2'd2
    } state_t;

    localparam logic [3:0] LAST_DATA = 4'd12;

    state_t     state;
    logic [7:0] shadow [13];
    logic [3:0] cnt;
    logic [7:0] csum;
    logic       accept;

    // A restart takes priority over any byte offered in the same cycle.
    assign accept     = data_valid && data_ready && !cfg_start;
    assign enable_out = enable_in && !cfg_busy;

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            cnt           <= 4'd0;
            csum          <= 8'd0;
            data_ready    <= 1'b0;
            cfg_busy      <= 1'b0;
            cfg_done      <= 1'b0;
            cfg_error     <= 1'b0;
            input_weights <= DEFAULT_WEIGHTS;
            neuron_params <= DEFAULT_PARAMS;
            for (int i = 0; i < 13; i++) begin
                shadow[i] <= 8'd0;
            end
        end else begin
            cfg_done  <= 1'b0;
            cfg_error <= 1'b0;
            if (cfg_start) begin
                state      <= LOAD;
                cnt        <= 4'd0;
                csum       <= 8'd0;
                data_ready <= 1'b1;
                cfg_busy   <= 1'b1;
            end else begin
                unique case (state)
                    IDLE: begin
                        data_ready <= 1'b0;
                        cfg_busy   <= 1'b0;
                    end
                    LOAD: begin
                        if (accept) begin
                            shadow[cnt] <= data_in;
                            csum        <= csum ^ data_in;
                            if (cnt == LAST_DATA) begin
                                state <= CHECK;
                            end else begin
                                cnt <= cnt + 4'd1;
                            end
                        end
                    end
                    CHECK: begin
                        if (accept) begin
                            state      <= IDLE;
                            data_ready <= 1'b0;
                            cfg_busy   <= 1'b0;
                            if ((csum ^ data_in) == 8'd0) begin
                                // Byte 0 lands in the top lane of the weight vector.
                                for (int k = 0; k < 9; k++) begin
                                    input_weights[71-8*k -: 8] <= shadow[k];
                                end
                                neuron_params <= {shadow[9], shadow[10],
                                                  shadow[11], shadow[12]};
                                cfg_done <= 1'b1;
                            end else begin
                                cfg_error <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        state      <= IDLE;
                        data_ready <= 1'b0;
                        cfg_busy   <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_snn_config_loader.sv
// Randomized self-checking bench for snn_config_loader against a
// frame-level reference model (byte list in, committed words out).
module tb_snn_config_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        cfg_start;
    logic [7:0]  data_in;
    logic        data_valid;
    logic        data_ready;
    logic        enable_in;
    logic        enable_out;
    logic [71:0] input_weights;
    logic [31:0] neuron_params;
    logic        cfg_busy;
    logic        cfg_done;
    logic        cfg_error;

    int checks = 0;
    int errors = 0;

    logic [7:0]  frm [14];
    logic [71:0] exp_w;
    logic [31:0] exp_p;

    always #5 clk = ~clk;

    snn_config_loader dut (
        .clk           (clk),
        .reset         (reset),
        .cfg_start     (cfg_start),
        .data_in       (data_in),
        .data_valid    (data_valid),
        .data_ready    (data_ready),
        .enable_in     (enable_in),
        .enable_out    (enable_out),
        .input_weights (input_weights),
        .neuron_params (neuron_params),
        .cfg_busy      (cfg_busy),
        .cfg_done      (cfg_done),
        .cfg_error     (cfg_error)
    );

    task automatic check_eq(input string tag, input logic [71:0] got,
                            input logic [71:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_defaults(input string tag);
        check_eq({tag, "_params"}, 72'(neuron_params), 72'h7F010200);
        check_eq({tag, "_weights"}, input_weights, 72'h0);
        check_eq({tag, "_busy"}, 72'(cfg_busy), 72'd0);
        check_eq({tag, "_ready"}, 72'(data_ready), 72'd0);
        check_eq({tag, "_done"}, 72'(cfg_done), 72'd0);
        check_eq({tag, "_error"}, 72'(cfg_error), 72'd0);
    endtask

    task automatic check_hold(input string tag);
        check_eq({tag, "_busy"}, 72'(cfg_busy), 72'd1);
        check_eq({tag, "_en"}, 72'(enable_out), 72'd0);
        check_eq({tag, "_pulse"}, 72'({cfg_done, cfg_error}), 72'd0);
        check_eq({tag, "_w"}, input_weights, exp_w);
        check_eq({tag, "_p"}, 72'(neuron_params), 72'(exp_p));
    endtask

    task automatic make_frame(input bit good);
        logic [7:0] x;
        x = 8'd0;
        for (int i = 0; i < 13; i++) begin
            frm[i] = 8'($urandom);
            x = x ^ frm[i];
        end
        frm[13] = good ? x : x ^ 8'($urandom_range(1, 255));
    endtask

    task automatic start_frame(input bit hold_valid);
        cfg_start  = 1'b1;
        data_valid = hold_valid;
        step();
        cfg_start  = 1'b0;
        data_valid = 1'b0;
        check_eq("start_ready", 72'(data_ready), 72'd1);
        check_hold("start");
    endtask

    // Offers bytes first..last with random idle gaps; bounded per byte.
    task automatic send_bytes(input int first, input int last,
                              input int gap_pct);
        for (int i = first; i <= last; i++) begin
            int waited = 0;
            forever begin
                data_valid = ($urandom_range(99) >= gap_pct);
                data_in = data_valid ? frm[i] : 8'($urandom);
                check_eq("ready_in_frame", 72'(data_ready), 72'd1);
                step();
                if (data_valid) break;
                waited++;
                if (waited > 60) begin
                    check_eq("valid_bound", 72'(waited), 72'd0);
                    break;
                end
                check_hold("gap");
            end
            data_valid = 1'b0;
            if (i != 13) check_hold("byte");
        end
    endtask

    // Reference: the frame is accepted iff all 14 bytes XOR to zero.
    task automatic check_result(input string tag);
        logic [7:0] x;
        x = 8'd0;
        for (int i = 0; i < 14; i++) x = x ^ frm[i];
        if (x == 8'd0) begin
            for (int k = 0; k < 9; k++) exp_w[71-8*k -: 8] = frm[k];
            exp_p = {frm[9], frm[10], frm[11], frm[12]};
        end
        check_eq({tag, "_done"}, 72'(cfg_done), 72'(x == 8'd0));
        check_eq({tag, "_error"}, 72'(cfg_error), 72'(x != 8'd0));
        check_eq({tag, "_busy"}, 72'(cfg_busy), 72'd0);
        check_eq({tag, "_ready"}, 72'(data_ready), 72'd0);
        check_eq({tag, "_w"}, input_weights, exp_w);
        check_eq({tag, "_p"}, 72'(neuron_params), 72'(exp_p));
        check_eq({tag, "_en"}, 72'(enable_out), 72'(enable_in));
        step();
        check_eq({tag, "_pulse_end"}, 72'({cfg_done, cfg_error}), 72'd0);
        check_eq({tag, "_w_held"}, input_weights, exp_w);
    endtask

    task automatic load_fixed(input logic [7:0] csum);
        logic [7:0] fixed [13];
        fixed = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07,
                  8'h08, 8'h09, 8'h40, 8'h02, 8'h03, 8'h01};
        for (int i = 0; i < 13; i++) frm[i] = fixed[i];
        frm[13] = csum;
    endtask

    initial begin
        reset      = 1'b1;
        cfg_start  = 1'b0;
        data_in    = 8'd0;
        data_valid = 1'b0;
        enable_in  = 1'b0;
        exp_w      = 72'h0;
        exp_p      = 32'h7F010200;
        step();
        step();
        reset = 1'b0;
        step();
        check_defaults("reset");
        for (int i = 0; i < 4; i++) begin
            enable_in = 1'(i);
            #1;
            check_eq("idle_en", 72'(enable_out), 72'(enable_in));
            step();
        end
        enable_in = 1'b1;

        // Fixed frame, back to back.
        load_fixed(8'h41);
        start_frame(1'b0);
        send_bytes(0, 13, 0);
        check_result("fixed");
        check_eq("fixed_w_const", input_weights, 72'h010203040506070809);
        check_eq("fixed_p_const", 72'(neuron_params), 72'h40020301);

        // Same frame, bad checksum.
        load_fixed(8'h42);
        start_frame(1'b0);
        send_bytes(0, 13, 0);
        check_result("badsum");

        // Valid held high while idle, then gapped delivery of a new frame.
        make_frame(1'b1);
        data_valid = 1'b1;
        data_in    = frm[0];
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("idle_valid_ready", 72'(data_ready), 72'd0);
            check_eq("idle_valid_busy", 72'(cfg_busy), 72'd0);
        end
        start_frame(1'b1);
        send_bytes(0, 13, 50);
        check_result("gapped");

        // Restart after byte 6 with a byte offered alongside the restart.
        make_frame(1'b1);
        start_frame(1'b0);
        send_bytes(0, 6, 20);
        data_in = frm[7];
        start_frame(1'b1);
        make_frame(1'b1);
        send_bytes(0, 13, 20);
        check_result("restart");

        // Randomized frames.
        for (int n = 0; n < 25; n++) begin
            make_frame($urandom_range(99) < 70);
            start_frame(1'b0);
            send_bytes(0, 13, int'($urandom_range(60)));
            check_result("rand");
        end

        // Reset in the middle of a frame.
        make_frame(1'b1);
        start_frame(1'b0);
        send_bytes(0, 8, 10);
        reset = 1'b1;
        step();
        reset = 1'b0;
        exp_w = 72'h0;
        exp_p = 32'h7F010200;
        check_defaults("midreset");
        check_eq("midreset_en", 72'(enable_out), 72'd1);
        step();
        check_defaults("postreset");

        // A full frame still works after the abort.
        make_frame(1'b1);
        start_frame(1'b0);
        send_bytes(0, 13, 30);
        check_result("after_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
